// File: rtl/uart_tx_pkg.sv
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared UART constants (clock, baud, frame length) and the
//                parity helper used by the transmitter. The optional parity
//                bit is selected with the UART_TX_PARITY_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

   localparam int UART_CLK_HZ    = 12_000_000;
   localparam int UART_BAUD      = 115_200;
   localparam int UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
   localparam int UART_FRAME_BITS = 11;
`else
   localparam int UART_FRAME_BITS = 10;
`endif

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
// ============================================================================
//  Module      : uart_tx_if
//  Description : Byte hand-over channel into the UART transmitter
//                (valid/ready handshake plus end-of-frame pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_if;
   logic       tx_valid;
   logic [7:0] tx_byte;
   logic       tx_ready;
   logic       tx_done;

   modport master (output tx_valid, output tx_byte, input tx_ready, input tx_done);
   modport slave  (input tx_valid, input tx_byte, output tx_ready, output tx_done);
endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Bit-period counter 0..CLKS_PER_BIT-1 with synchronous clear;
//                tick marks the last cycle of a bit, tick_next the one before.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 104
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic clr,
   output logic      tick,
   output logic      tick_next
);

   localparam int              CNT_W  = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] C_PRE  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr || (r_cnt == C_LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign tick      = !clr && (r_cnt == C_LAST);
   assign tick_next = !clr && (r_cnt == C_PRE);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter: start, 8 data bits LSB first, optional even
//                parity (macro UART_TX_PARITY_EN), one stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLK_HZ = UART_CLK_HZ,
   parameter int BAUD   = UART_BAUD
) (
   input  wire logic  clk,
   input  wire logic  rst,
   uart_tx_if.slave   bus,
   output logic       tx
);

   localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam logic [2:0] C_LAST_BIT   = 3'(UART_DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd3
   } state_t;

   state_t     r_state;
   logic [7:0] r_shreg;
   logic [2:0] r_bit_idx;
   logic       r_tx;
   logic       r_ready;
   logic       r_done;
`ifdef UART_TX_PARITY_EN
   logic       r_parity;
`endif

   logic w_accept;
   logic w_tick;
   logic w_tick_next;

   assign w_accept = bus.tx_valid && r_ready;

   // Counter is held at zero while idle so every frame starts phase-aligned.
   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk       (clk),
      .rst       (rst),
      .clr       (r_state == S_IDLE),
      .tick      (w_tick),
      .tick_next (w_tick_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_shreg   <= '0;
         r_bit_idx <= '0;
         r_tx      <= 1'b1;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_shreg   <= bus.tx_byte;
                  r_bit_idx <= '0;
                  r_tx      <= 1'b0;
                  r_ready   <= 1'b0;
                  r_state   <= S_START;
`ifdef UART_TX_PARITY_EN
                  r_parity  <= even_parity(bus.tx_byte);
`endif
               end
            end
            S_START: begin
               if (w_tick) begin
                  r_tx    <= r_shreg[0];
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  if (r_bit_idx == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     r_tx    <= r_parity;
                     r_state <= S_PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_shreg   <= r_shreg >> 1;
                     r_tx      <= r_shreg[1];
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_tick) begin
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               // Registered pulse lands on the final stop-bit cycle.
               if (w_tick_next) begin
                  r_done <= 1'b1;
               end
               if (w_tick) begin
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign tx           = r_tx;
   assign bus.tx_ready = r_ready;
   assign bus.tx_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Scoreboard bench for uart_tx; honours UART_TX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

   localparam int CPB = 12_000_000 / 115_200;
`ifdef UART_TX_PARITY_EN
   localparam int F = 11;
`else
   localparam int F = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx;

   uart_tx_if bus ();

   uart_tx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .tx  (tx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] b;
      int         n;
   } frame_t;

   frame_t q[$];
   int vectors     = 0;
   int miscompares = 0;
   int n_acc       = 0;
   int last_acc    = 0;
   int n_completed = 0;
   int done_seen   = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Frame level k: 0=start, 1..8 data LSB first, optional even parity, then stop.
   function automatic int line_level(input logic [7:0] b, input int k);
      if (k == 0) return 0;
      if (k <= 8) return int'(b[k-1]);
      if (F == 11 && k == 9) return int'(^b);
      return 1;
   endfunction

   // Scoreboard: accepts into the model when idle, checks every cycle.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         check("reset_tx", int'(tx), 1);
         check("reset_ready", int'(bus.tx_ready), 1);
         check("reset_done", int'(bus.tx_done), 0);
      end else begin
         if (bus.tx_done === 1'b1) done_seen++;
         if (q.size() == 0) begin
            check("idle_tx", int'(tx), 1);
            check("idle_ready", int'(bus.tx_ready), 1);
            check("idle_done", int'(bus.tx_done), 0);
            if (bus.tx_valid) begin
               q.push_back('{b: bus.tx_byte, n: cyc});
               last_acc = cyc;
               n_acc++;
            end
         end else begin
            int off;
            off = cyc - q[0].n;
            check("frame_tx", int'(tx), line_level(q[0].b, (off - 1) / CPB));
            check("frame_ready", int'(bus.tx_ready), 0);
            check("frame_done", int'(bus.tx_done), int'(off == F * CPB));
            if (off == F * CPB) begin
               void'(q.pop_front());
               n_completed++;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic step_to(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic wait_acc(input int target);
      for (int i = 0; i < 3000 && n_acc < target; i++) step(1);
      if (n_acc < target) check("accept_timeout", n_acc, target);
   endtask

   task automatic send(input logic [7:0] b);
      int t;
      t = n_acc + 1;
      bus.tx_byte  = b;
      bus.tx_valid = 1'b1;
      wait_acc(t);
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000 && q.size() != 0; i++) step(1);
      if (q.size() != 0) check("idle_timeout", q.size(), 0);
      step(1);
   endtask

   task automatic reset_at(input int c);
      step_to(c);
      rst = 1'b1;
      #1;
      check("async_rst_tx", int'(tx), 1);
      check("async_rst_ready", int'(bus.tx_ready), 1);
      check("async_rst_done", int'(bus.tx_done), 0);
      step(2);
      rst = 1'b0;
      step(2);
   endtask

   initial begin
      int t;
      bus.tx_valid = 1'b0;
      bus.tx_byte  = 8'h00;
      step(3);
      rst = 1'b0;
      step(2);

      send(8'h55);
      wait_idle();

      send(8'hA3);
      step_to(last_acc + 300);
      bus.tx_byte = 8'hFF;
      wait_idle();

      // Back-to-back with valid held high across the idle cycle.
      t = n_acc;
      bus.tx_byte  = 8'h00;
      bus.tx_valid = 1'b1;
      wait_acc(t + 1);
      bus.tx_byte = 8'hFF;
      wait_acc(t + 2);
      bus.tx_valid = 1'b0;
      wait_idle();

      send(8'h3C);
      reset_at(last_acc + 500);
      send(8'h3C);
      reset_at(last_acc + 50);
      send(8'h3C);
      wait_idle();

      send(8'h00);
      step_to(last_acc + 200);
      bus.tx_byte  = 8'h11;
      bus.tx_valid = 1'b1;
      step(1);
      bus.tx_valid = 1'b0;
      wait_idle();

      send(8'h07);
      wait_idle();
      send(8'h03);
      wait_idle();

      for (int i = 0; i < 14; i++) begin
         send(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 1) == 1) begin
            step_to(last_acc + int'($urandom_range(2, F * CPB - 2)));
            bus.tx_byte  = 8'($urandom_range(0, 255));
            bus.tx_valid = 1'b1;
            step(1);
            bus.tx_valid = 1'b0;
         end
         wait_idle();
         step(int'($urandom_range(0, 5)));
      end

      check("done_pulse_count", done_seen, n_completed);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
